sram_port_arbiter: RTL
======================

# sram_port_arbiter

Shares one single-port, fixed-latency unified SRAM between the core's instruction-fetch and data-access ports. It arbitrates per cycle, with data priority and a starvation guard for fetch, and drives the SRAM strobes. It tags each issued read so the one-cycle-later return data is steered to the correct requester. It sits between the core's inst/data SRAM interfaces and the simulation memory model.

## Interface
- ADDR_W, 32, byte address width
- MAX_WAIT, 4, consecutive cycles fetch may be denied while requesting before it is forced to win (range 1..15)

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request; held with addr stable until inst_gnt
- inst_addr  in  ADDR_W  fetch byte address, 4-byte aligned
- inst_gnt  out  1  fetch request accepted this cycle
- inst_rvalid  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  data request; held with all fields stable until data_gnt
- data_wstrb  in  8  byte write strobes; 0 = read
- data_addr  in  ADDR_W  data byte address, 8-byte aligned
- data_wdata  in  64  write data
- data_gnt  out  1  data request accepted this cycle
- data_rvalid  out  1  read data valid (reads only)
- data_rdata  out  64  read data
- mem_en  out  1  SRAM access this cycle
- mem_wen  out  8  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address, bits [2:0] forced to 0
- mem_wdata  out  64  SRAM write data
- mem_rdata  in  64  SRAM read data, valid the cycle after mem_en with mem_wen==0

## Operation
- At most one grant per cycle. Grant is combinational from the requests and the registered arbitration state.
- Priority: data wins by default. Fetch wins if only fetch requests. Fetch also wins if both request and starve_cnt == MAX_WAIT.
- starve_cnt (4 bits): increments (saturating at MAX_WAIT) each cycle inst_req=1 and inst_gnt=0. Clears on inst_gnt or when inst_req=0.
- Granted fetch: mem_en=1, mem_wen=0, mem_addr={inst_addr[ADDR_W-1:3],3'b0}. The response tag records FETCH and inst_addr[2].
- Granted data: mem_en=1, mem_wen=data_wstrb, mem_addr aligned, mem_wdata=data_wdata. The tag records DATA_RD only if data_wstrb==0. Writes record IDLE.
- No grant: mem_en=0, mem_wen=0. The tag records IDLE.
- Response steering, cycle after issue:
  - Tag FETCH: inst_rvalid=1, inst_rdata = sel ? mem_rdata[63:32] : mem_rdata[31:0].
  - Tag DATA_RD: data_rvalid=1, data_rdata=mem_rdata.
- The rdata outputs pass mem_rdata through unregistered. Their values are don't-care when the matching rvalid is 0.
- Writes produce no rvalid. Write completion is implied by data_gnt.
- Requesters may issue back-to-back. A new grant and the previous response coexist in the same cycle.

## Timing
- Grant and mem_* strobes: same cycle as the winning request (0 cycles).
- Read data: exactly 1 cycle after grant. No buffering; no backpressure on responses.
- Reset asserted (async): tag=IDLE, starve_cnt=0, so inst_rvalid=0 and data_rvalid=0 immediately.
- While reset is asserted: inst_gnt=0, data_gnt=0, mem_en=0, mem_wen=0. Requests are ignored.
- Reset mid-operation: the in-flight read response is dropped and never delivered. First grants are possible in the first cycle after deassertion.
- Simultaneous requests with starve_cnt==MAX_WAIT: fetch is granted, data waits, starve_cnt clears. Data is granted the next cycle unless fetch again has sole request.
- Saturation: starve_cnt never exceeds MAX_WAIT and never wraps.
- Fetch requesting alone never increments starve_cnt.

## Structure
- Shared package sram_arb_pkg:
  - enum resp_tag_e {TAG_IDLE, TAG_FETCH, TAG_DATA_RD}
  - localparams MEM_DW=64, INST_DW=32, WSTRB_W=8
- No sub-module is needed. Arbitration, starvation counter and tag register live in one module.
- Registered state: tag (2 bits), sel (1 bit), starve_cnt (4 bits).

## Test plan
- Contention, MAX_WAIT=4: inst_req and data_req both held high from cycle 0 -> data_gnt in cycles 0-3, inst_gnt in cycle 4, data_gnt in cycle 5.
- Fetch word select: inst read at 0x8000_0004, mem_rdata=0xAAAA_BBBB_CCCC_DDDD -> next cycle inst_rvalid=1, inst_rdata=0xAAAA_BBBB. Repeat at 0x8000_0000 -> inst_rdata=0xCCCC_DDDD.
- Data write: data_wstrb=0xF0, data_addr=0x8000_1008 -> same cycle mem_en=1, mem_wen=0xF0, mem_addr=0x8000_1008; next cycle data_rvalid=0 and inst_rvalid=0.
- Back-to-back mix: data read at cycle 0, fetch at cycle 1 -> data_rvalid at cycle 1 together with inst_gnt; inst_rvalid at cycle 2.
- Reset mid-read: data read granted at cycle 0, reset asserted cycle 1 -> data_rvalid=0 immediately; gnt=0 and mem_en=0 while reset is held.
- Solo fetch for 20 cycles, then a data request arrives -> starve_cnt stays 0 and data is granted immediately.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the unified-SRAM port arbiter.
package sram_arb_pkg;

  localparam int MEM_DW  = 64;
  localparam int INST_DW = 32;
  localparam int WSTRB_W = 8;

  typedef enum logic [1:0] {
    TAG_IDLE    = 2'd0,
    TAG_FETCH   = 2'd1,
    TAG_DATA_RD = 2'd2
  } resp_tag_e;

endpackage

// File: rtl/sram_port_arbiter.sv
// Per-cycle arbiter sharing one single-port SRAM between fetch and data ports,
// with data priority, a fetch starvation guard and one-cycle response steering.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [INST_DW-1:0]  inst_rdata,
  input  logic                data_req,
  input  logic [WSTRB_W-1:0]  data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [MEM_DW-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [MEM_DW-1:0]   data_rdata,
  output logic                mem_en,
  output logic [WSTRB_W-1:0]  mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [MEM_DW-1:0]   mem_wdata,
  input  logic [MEM_DW-1:0]   mem_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  resp_tag_e  tag_q, tag_d;
  logic       sel_q, sel_d;
  logic [3:0] starve_q, starve_d;

  logic inst_req_v, data_req_v;
  logic unused_addr_bits;

  // Requests are masked during reset so grants and strobes stay low
  // even though reset is asynchronous to the combinational grant path.
  assign inst_req_v = inst_req & ~reset;
  assign data_req_v = data_req & ~reset;

  assign unused_addr_bits = ^{inst_addr[1:0], data_addr[2:0]};

  // NOTE: every output of this block gets a default first, so no path
  // through the if/else leaves a signal unassigned and infers a latch.
  always_comb begin
    inst_gnt  = 1'b0;
    data_gnt  = 1'b0;
    mem_en    = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = data_wdata;
    tag_d     = TAG_IDLE;
    sel_d     = 1'b0;
    starve_d  = 4'd0;

    if (inst_req_v && (!data_req_v || starve_q == MAX_WAIT_C)) begin
      inst_gnt = 1'b1;
      mem_en   = 1'b1;
      mem_addr = {inst_addr[ADDR_W-1:3], 3'b000};
      tag_d    = TAG_FETCH;
      sel_d    = inst_addr[2];
    end else if (data_req_v) begin
      data_gnt = 1'b1;
      mem_en   = 1'b1;
      mem_wen  = data_wstrb;
      mem_addr = {data_addr[ADDR_W-1:3], 3'b000};
      tag_d    = (data_wstrb == '0) ? TAG_DATA_RD : TAG_IDLE;
    end

    // Fetch loses only when both request; saturate rather than wrap.
    if (inst_req_v && !inst_gnt)
      starve_d = (starve_q < MAX_WAIT_C) ? starve_q + 4'd1 : starve_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_q    <= TAG_IDLE;
      sel_q    <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      tag_q    <= tag_d;
      sel_q    <= sel_d;
      starve_q <= starve_d;
    end
  end

  assign inst_rvalid = (tag_q == TAG_FETCH);
  assign data_rvalid = (tag_q == TAG_DATA_RD);
  assign inst_rdata  = sel_q ? mem_rdata[63:32] : mem_rdata[31:0];
  assign data_rdata  = mem_rdata;

endmodule
